// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_select.sv
// Round-robin priority selector: first set bit of req searching upward from last+1.
module rr_select #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter that lets one requester at a time write a shared FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              owner_valid;

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req  (req_valid),
        .last (last_q),
        .found(sel_found),
        .idx  (sel_idx)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        beat_d        = beat_q;
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        grant_id      = '0;
        busy          = 1'b0;
        owner_valid   = req_valid[owner_q];

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    owner_d = sel_idx;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!fifo_full) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_d == BEAT_LAST) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced low while rst is high so a mid-burst reset never writes.
        if (!rst && state_q == GRANT) begin
            busy               = 1'b1;
            grant_id           = owner_q;
            req_ready[owner_q] = !fifo_full;
            fifo_write_en      = owner_valid && !fifo_full;
            if (fifo_write_en) begin
                fifo_data_in = req_data[owner_q*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            beat_q  <= '0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle check against a behavioural model plus
// hand-computed write-order expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_write_en;
    logic [W-1:0]     fifo_data_in;
    logic [IW-1:0]    grant_id;
    logic             busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (N),
        .WIDTH    (W),
        .MAX_BURST(MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the FIFO, how many beats so far, who was served last.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_beats = 0;
    int m_last  = N - 1;

    // Sources: requester i offers base[i]+ptr[i] while remain[i] beats are left.
    int remain[N];
    int ptr[N];
    int base[N];
    int log_id[$];
    int log_dat[$];
    bit chk_nonowner = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = remain[i] > 0;
            req_data[i*W +: W] = W'(base[i] + ptr[i]);
        end
    endtask

    task automatic compare();
        int e_ready, e_we, e_dat, e_gid, e_busy;
        e_ready = 0; e_we = 0; e_dat = 0; e_gid = 0; e_busy = 0;
        if (!rst && m_busy) begin
            e_busy = 1;
            e_gid  = m_owner;
            if (!fifo_full) e_ready = 1 << m_owner;
            if (req_valid[m_owner] && !fifo_full) begin
                e_we  = 1;
                e_dat = base[m_owner] + ptr[m_owner];
            end
        end
        check("req_ready", int'(req_ready), e_ready);
        check("fifo_write_en", int'(fifo_write_en), e_we);
        check("fifo_data_in", int'(fifo_data_in), e_dat);
        check("grant_id", int'(grant_id), e_gid);
        check("busy", int'(busy), e_busy);
        check("ready_onehot", int'($countones(req_ready) <= 1), 1);
        if (chk_nonowner && grant_id == 0 && fifo_write_en)
            check("no_req3_data", int'(fifo_data_in[7:4] != 4'hD), 1);
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_beats = 0; m_last = N - 1;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req_valid[c]) begin
                    m_busy = 1'b1; m_owner = c; m_beats = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 1'b0; m_last = m_owner;
        end else if (!fifo_full) begin
            log_id.push_back(m_owner);
            log_dat.push_back(base[m_owner] + ptr[m_owner]);
            ptr[m_owner]++;
            remain[m_owner]--;
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0; m_last = m_owner;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            remain[i] = 0; ptr[i] = 0; base[i] = 0;
        end
        drive();
        run(2);
        rst = 1'b0;
        log_id.delete();
        log_dat.delete();
    endtask

    task automatic wait_ptr(input int i, input int n);
        int k;
        k = 0;
        while (ptr[i] < n && k < 50) begin
            cycle();
            k++;
        end
        check("wait_ptr", ptr[i], n);
    endtask

    task automatic check_log(input string name, input int idx, input int id, input int dat);
        if (idx < log_id.size()) begin
            check({name, "_id"}, log_id[idx], id);
            check({name, "_data"}, log_dat[idx], dat);
        end else begin
            check({name, "_missing"}, -1, dat);
        end
    endtask

    initial begin
        rst = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data = '0;

        // Single requester, 6 beats: burst of 4, bubble, burst of 2.
        do_reset();
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(req_ready), 0);
        base[0] = 'hA0; remain[0] = 6; drive();
        cycle();
        #2;
        check("t1_grant_busy", int'(busy), 1);
        check("t1_grant_id", int'(grant_id), 0);
        run(14);
        check("t1_len", log_id.size(), 6);
        for (int k = 0; k < 6; k++) check_log("t1", k, 0, 'hA0 + k);

        // All four continuously valid: grants rotate 0,1,2,3,0 with 4 beats each.
        do_reset();
        for (int i = 0; i < N; i++) begin
            base[i] = 16 * i; remain[i] = 8;
        end
        drive();
        run(26);
        for (int k = 0; k < 20; k++)
            check_log("t2", k, (k / 4) % 4, 16 * ((k / 4) % 4) + 4 * (k / 16) + (k % 4));

        // Requester 1 stalled by fifo_full after 2 beats.
        do_reset();
        base[1] = 'h50; remain[1] = 4; drive();
        wait_ptr(1, 2);
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t3_full_we", int'(fifo_write_en), 0);
            check("t3_full_ready", int'(req_ready), 0);
            check("t3_full_grant", int'(grant_id), 1);
            cycle();
        end
        fifo_full = 1'b0;
        run(5);
        check("t3_len", log_id.size(), 4);
        for (int k = 0; k < 4; k++) check_log("t3", k, 1, 'h50 + k);

        // Requester 2 releases early after 1 beat; requester 3 follows.
        do_reset();
        base[2] = 'h60; remain[2] = 1;
        base[3] = 'h70; remain[3] = 4;
        drive();
        run(10);
        check_log("t4", 0, 2, 'h60);
        for (int k = 1; k < 5; k++) check_log("t4", k, 3, 'h70 + k - 1);

        // Reset during beat 3 of requester 0; requester 0 still wins afterwards.
        do_reset();
        base[0] = 'h80; remain[0] = 8; drive();
        wait_ptr(0, 2);
        rst = 1'b1;
        #2;
        check("t5_rst_we", int'(fifo_write_en), 0);
        cycle();
        rst = 1'b0;
        base[1] = 'h90; remain[1] = 4; drive();
        #2;
        check("t5_post_busy", int'(busy), 0);
        check("t5_post_we", int'(fifo_write_en), 0);
        check("t5_post_data", int'(fifo_data_in), 0);
        check("t5_post_gid", int'(grant_id), 0);
        run(14);
        check_log("t5", 0, 0, 'h80);
        check_log("t5", 1, 0, 'h81);
        for (int k = 2; k < 6; k++) check_log("t5", k, 0, 'h80 + k);
        for (int k = 6; k < 10; k++) check_log("t5", k, 1, 'h90 + k - 6);

        // Requesters 0 and 3 contend; requester 3 data must never leak under grant 0.
        do_reset();
        chk_nonowner = 1'b1;
        base[0] = 'hC0; remain[0] = 8;
        base[3] = 'hD0; remain[3] = 8;
        drive();
        run(24);
        chk_nonowner = 1'b0;
        for (int k = 0; k < 4; k++) check_log("t6a", k, 0, 'hC0 + k);
        for (int k = 4; k < 8; k++) check_log("t6b", k, 3, 'hD0 + k - 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data width, matching the downstream FIFO.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
REQ-009 SHALL have port fifo_full  input  1  full flag from the shared FIFO.
REQ-010 SHALL have port fifo_write_en  output  1  FIFO write strobe.
REQ-011 SHALL have port fifo_data_in  output  WIDTH  FIFO write data.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the current owner; 0 when idle.
REQ-013 SHALL have port busy  output  1  high while in GRANT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 In IDLE with any req_valid high: SHALL select the first valid requester searching round-robin from last_grant+1 (mod NUM_REQ), register it as owner, and enter GRANT next cycle.
REQ-016 Arbitration latency SHALL be exactly one cycle: no transfer in the IDLE cycle.
REQ-017 In GRANT: req_ready[owner] SHALL be !fifo_full, combinationally; all other req_ready bits SHALL be 0.
REQ-018 fifo_write_en SHALL equal req_valid[owner] && req_ready[owner]; fifo_data_in SHALL be the owner's req_data slice, and SHALL be 0 when fifo_write_en is low.
REQ-019 A beat counter SHALL be 0 on grant and increment per transfer; width is $clog2(MAX_BURST+1).
REQ-020 GRANT SHALL return to IDLE after the transfer that makes the beat count equal MAX_BURST.
REQ-021 GRANT SHALL return to IDLE in any cycle where req_valid[owner] is low (early release); no transfer occurs in that cycle.
REQ-022 While fifo_full is high with req_valid[owner] high: SHALL hold grant, hold the beat count, and not write; the grant has no timeout.
REQ-023 On each GRANT->IDLE exit: last_grant SHALL be set to owner.
REQ-024 Requests arriving during GRANT SHALL wait; no preemption.
REQ-025 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0,...
REQ-026 Data from a non-owner SHALL never reach the FIFO.

Reset
REQ-027 On rst high at a clock edge: state=IDLE, owner=0, beat count=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-028 Output values during and after reset: req_ready=0, fifo_write_en=0, fifo_data_in=0, grant_id=0, busy=0.
REQ-029 Reset asserted mid-burst SHALL abort the grant with no write in the reset cycle.

Structure
REQ-030 A shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the default parameter constants.
REQ-031 The round-robin priority selector SHALL be a sub-module rr_select (inputs req vector and last index; outputs a found flag and the index), with combinational logic only.
REQ-032 All state SHALL be in one clocked process.

Verification
REQ-033 Reset then req_valid=4'b0001 held, data 0xA0..0xA5 -> grant_id=0 from cycle 2; writes A0..A3 (4 beats); 1-cycle IDLE bubble; re-grant to 0; A4,A5 written.
REQ-034 All four valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; 4 writes each; one idle cycle between bursts.
REQ-035 Owner 1 mid-burst at beat 2, fifo_full=1 for 3 cycles -> fifo_write_en=0 and req_ready=0 for those 3 cycles; grant held; remaining 2 beats complete after full drops.
REQ-036 Owner 2 drops req_valid after 1 beat while requester 3 is valid -> GRANT exits, IDLE for one cycle, then grant_id=3; last_grant=2.
REQ-037 rst pulsed at beat 3 of requester 0's burst -> no write in the reset cycle; all outputs 0 next cycle; with requester 0 and 1 valid afterwards, requester 0 is granted first.
REQ-038 Requesters 0 and 3 valid; check every cycle -> fifo_data_in never carries requester 3 data while grant_id=0; at most one req_ready bit high at any time.
